// File: rtl/prco_pc_sequencer_pkg.sv
// Shared types and width helpers for the program-counter sequencer.
package prco_pc_sequencer_pkg;

   typedef enum logic [2:0] {
      PCS_INIT  = 3'd0,
      PCS_WAIT  = 3'd1,
      PCS_FLUSH = 3'd2,
      PCS_HALT  = 3'd3,
      PCS_BREAK = 3'd4
   } pcs_state_t;

   // Flush counter only ever holds 0..BRANCH_FLUSH; keep at least one bit.
   function automatic int unsigned cnt_width(input int unsigned flush);
      return (flush < 2) ? 1 : $clog2(flush + 1);
   endfunction

   function automatic int unsigned idx_width(input int unsigned num);
      return (num < 2) ? 1 : $clog2(num);
   endfunction

endpackage

// File: rtl/prco_pc_sequencer_bp_match.sv
// Breakpoint register bank and address comparators; q_match is set when any
// valid breakpoint equals i_cmp_addr.
module prco_bp_match
   import prco_pc_sequencer_pkg::*;
#(
   parameter int unsigned NUM_BP = 2,
   parameter int unsigned PC_W   = 16
) (
   input  logic                         i_clk,
   input  logic                         i_reset_n,
   input  logic                         i_we,
   input  logic [idx_width(NUM_BP)-1:0] i_idx,
   input  logic [PC_W-1:0]              i_addr,
   input  logic [PC_W-1:0]              i_cmp_addr,
   output logic                         q_match
);

   localparam int unsigned IDX_W = idx_width(NUM_BP);

   logic [PC_W-1:0]   bp_addr [NUM_BP];
   logic [NUM_BP-1:0] bp_valid;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         bp_valid <= '0;
         for (int unsigned i = 0; i < NUM_BP; i++) begin
            bp_addr[i] <= '0;
         end
      end else if (i_we) begin
         for (int unsigned i = 0; i < NUM_BP; i++) begin
            if (i_idx == IDX_W'(i)) begin
               bp_addr[i]  <= i_addr;
               bp_valid[i] <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      q_match = 1'b0;
      for (int unsigned i = 0; i < NUM_BP; i++) begin
         if (bp_valid[i] && (bp_addr[i] == i_cmp_addr)) begin
            q_match = 1'b1;
         end
      end
   end

endmodule

// File: rtl/prco_pc_sequencer.sv
// Program-counter sequencer: one fetch strobe per retired instruction, branch
// redirect after a flush window, halt, debug single-step. Breakpoints: PRCO_BREAKPOINT_EN.
module prco_pc_sequencer
   import prco_pc_sequencer_pkg::*;
#(
   parameter int unsigned PC_W         = 16,
   parameter int unsigned RESET_PC     = 0,
   parameter int unsigned BRANCH_FLUSH = 3,
   parameter int unsigned NUM_BP       = 2
) (
   input  logic                         i_clk,
   input  logic                         i_reset_n,
   input  logic                         i_en,
   input  logic                         i_mode,
   input  logic                         i_step,
   input  logic                         i_ce,
   input  logic                         i_branch,
   input  logic [PC_W-1:0]              i_branch_target,
   input  logic                         i_halt,
   input  logic                         i_bp_we,
   input  logic [idx_width(NUM_BP)-1:0] i_bp_idx,
   input  logic [PC_W-1:0]              i_bp_addr,
   output logic [PC_W-1:0]              q_pc,
   output logic                         q_ce,
   output logic                         q_debug_instr_clk,
   output logic                         q_halted,
   output logic                         q_bp_hit
);

   localparam int unsigned      CNT_W     = cnt_width(BRANCH_FLUSH);
   localparam logic [PC_W-1:0]  PC_RST    = PC_W'(RESET_PC);
   localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(BRANCH_FLUSH);
   localparam bit               DIRECT_BR = (BRANCH_FLUSH == 0);

   pcs_state_t       state;
   logic [PC_W-1:0]  target;
   logic [PC_W-1:0]  bp_pc;
   logic [CNT_W-1:0] cnt;
   logic             done_pend;
   logic             step_prev;

   logic             step_edge;
   logic             br_now;
   logic             br_direct;
   logic             seq_go;
   logic             flush_go;
   logic             issue_go;
   logic [PC_W-1:0]  cand_pc;
   logic             bp_match;

   assign step_edge = i_step & ~step_prev;
   assign br_now    = i_branch && ((state == PCS_WAIT) || (state == PCS_FLUSH));
   // A zero-length flush fetches the target straight away unless a strobe is
   // already out; then it takes a one-cycle trip through FLUSH with cnt=0.
   assign br_direct = br_now && DIRECT_BR && !q_ce;
   assign seq_go    = (state == PCS_WAIT) && !i_branch && done_pend && !q_ce &&
                      (!i_mode || step_edge);
   // cnt counts remaining idle cycles including the current one, so the fetch
   // lands exactly BRANCH_FLUSH cycles after the branch is accepted.
   assign flush_go  = (state == PCS_FLUSH) && !i_branch && (cnt <= CNT_W'(1));
   assign issue_go  = br_direct || seq_go || flush_go;

   always_comb begin
      if (br_direct)
         cand_pc = i_branch_target;
      else if (state == PCS_FLUSH)
         cand_pc = target;
      else
         cand_pc = q_pc + PC_W'(1);
   end

`ifdef PRCO_BREAKPOINT_EN
   prco_bp_match #(
      .NUM_BP (NUM_BP),
      .PC_W   (PC_W)
   ) u_bp_match (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .i_we       (i_bp_we),
      .i_idx      (i_bp_idx),
      .i_addr     (i_bp_addr),
      .i_cmp_addr (cand_pc),
      .q_match    (bp_match)
   );
`else
   logic unused_bp;
   assign unused_bp = ^{i_bp_we, i_bp_idx, i_bp_addr};
   assign bp_match  = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state             <= PCS_INIT;
         q_pc              <= PC_RST;
         q_ce              <= 1'b0;
         q_debug_instr_clk <= 1'b0;
         q_halted          <= 1'b0;
         q_bp_hit          <= 1'b0;
         done_pend         <= 1'b0;
         step_prev         <= 1'b0;
         target            <= '0;
         bp_pc             <= '0;
         cnt               <= '0;
      end else if (!i_en) begin
         // Completion is still recorded; strobes drop so they stay one cycle wide.
         if (i_ce)
            done_pend <= 1'b1;
         q_ce              <= 1'b0;
         q_debug_instr_clk <= 1'b0;
      end else begin
         step_prev         <= i_step;
         q_ce              <= 1'b0;
         q_debug_instr_clk <= 1'b0;
         if (i_ce)
            done_pend <= 1'b1;

         if (i_halt) begin
            state    <= PCS_HALT;
            q_halted <= 1'b1;
         end else begin
            case (state)
               PCS_INIT: begin
                  q_pc  <= PC_RST;
                  q_ce  <= 1'b1;
                  state <= PCS_WAIT;
               end
               PCS_WAIT, PCS_FLUSH: begin
                  if (br_now) begin
                     done_pend <= 1'b0;
                     target    <= i_branch_target;
                     cnt       <= CNT_LOAD;
                     state     <= PCS_FLUSH;
                  end else if ((state == PCS_FLUSH) && !flush_go) begin
                     cnt <= cnt - CNT_W'(1);
                  end
                  if (issue_go) begin
                     if (seq_go)
                        done_pend <= i_ce;
                     if (bp_match) begin
                        state    <= PCS_BREAK;
                        q_bp_hit <= 1'b1;
                        bp_pc    <= cand_pc;
                     end else begin
                        q_pc              <= cand_pc;
                        q_ce              <= 1'b1;
                        q_debug_instr_clk <= seq_go;
                        state             <= PCS_WAIT;
                     end
                  end
               end
               PCS_BREAK: begin
                  if (step_edge) begin
                     q_pc              <= bp_pc;
                     q_ce              <= 1'b1;
                     q_debug_instr_clk <= 1'b1;
                     q_bp_hit          <= 1'b0;
                     state             <= PCS_WAIT;
                  end
               end
               PCS_HALT: begin
                  q_halted <= 1'b1;
               end
               default: begin
                  state <= PCS_INIT;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_prco_pc_sequencer.sv
// Directed-vector bench for prco_pc_sequencer: a 16-bit / 3-cycle-flush instance
// and a 4-bit / zero-flush instance sharing clock and reset.
module tb_prco_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        en, mode, step, ce, br, halt, bp_we;
   logic [0:0]  bp_idx;
   logic [15:0] tgt, bp_addr;
   logic [15:0] pc;
   logic        qce, qdbg, qhalt, qbp;

   logic        ce4, br4, halt4;
   logic [3:0]  tgt4, pc4;
   logic        qce4, qdbg4, qhalt4, qbp4;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   int unsigned pulses;

   prco_pc_sequencer #(
      .PC_W         (16),
      .RESET_PC     (0),
      .BRANCH_FLUSH (3),
      .NUM_BP       (2)
   ) u_dut (
      .i_clk             (clk),
      .i_reset_n         (rst_n),
      .i_en              (en),
      .i_mode            (mode),
      .i_step            (step),
      .i_ce              (ce),
      .i_branch          (br),
      .i_branch_target   (tgt),
      .i_halt            (halt),
      .i_bp_we           (bp_we),
      .i_bp_idx          (bp_idx),
      .i_bp_addr         (bp_addr),
      .q_pc              (pc),
      .q_ce              (qce),
      .q_debug_instr_clk (qdbg),
      .q_halted          (qhalt),
      .q_bp_hit          (qbp)
   );

   prco_pc_sequencer #(
      .PC_W         (4),
      .RESET_PC     (0),
      .BRANCH_FLUSH (0),
      .NUM_BP       (2)
   ) u_dut4 (
      .i_clk             (clk),
      .i_reset_n         (rst_n),
      .i_en              (en),
      .i_mode            (1'b0),
      .i_step            (1'b0),
      .i_ce              (ce4),
      .i_branch          (br4),
      .i_branch_target   (tgt4),
      .i_halt            (halt4),
      .i_bp_we           (1'b0),
      .i_bp_idx          (1'b0),
      .i_bp_addr         (4'h0),
      .q_pc              (pc4),
      .q_ce              (qce4),
      .q_debug_instr_clk (qdbg4),
      .q_halted          (qhalt4),
      .q_bp_hit          (qbp4)
   );

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      en = 1'b1; mode = 1'b0; step = 1'b0; ce = 1'b0; br = 1'b0; halt = 1'b0;
      bp_we = 1'b0; bp_idx = '0; tgt = '0; bp_addr = '0;
      ce4 = 1'b0; br4 = 1'b0; halt4 = 1'b0; tgt4 = '0;

      repeat (3) tick();
      check_vec("rst_pc", 32'(pc), 32'h0);
      check_vec("rst_ce", 32'(qce), 32'h0);
      check_vec("rst_dbg", 32'(qdbg), 32'h0);
      check_vec("rst_halted", 32'(qhalt), 32'h0);
      check_vec("rst_bp_hit", 32'(qbp), 32'h0);

      // Run mode: first fetch, then one issue per i_ce, strobes 4 cycles apart
      rst_n = 1'b1;
      tick();
      check_vec("init_ce", 32'(qce), 32'h1);
      check_vec("init_pc", 32'(pc), 32'h0);
      for (int k = 1; k <= 3; k++) begin
         tick();
         check_vec("run_gap1", 32'(qce), 32'h0);
         tick();
         check_vec("run_gap2", 32'(qce), 32'h0);
         ce = 1'b1;
         tick();
         ce = 1'b0;
         check_vec("run_gap3", 32'(qce), 32'h0);
         tick();
         check_vec("run_ce", 32'(qce), 32'h1);
         check_vec("run_pc", 32'(pc), 32'(k));
         check_vec("run_dbg", 32'(qdbg), 32'h1);
      end

      // Debug single-step: a held step gives one issue only
      mode = 1'b1;
      ce = 1'b1;
      tick();
      ce = 1'b0;
      tick();
      check_vec("dbg_wait_step", 32'(qce), 32'h0);
      step = 1'b1;
      tick();
      check_vec("dbg_step_ce", 32'(qce), 32'h1);
      check_vec("dbg_step_pc", 32'(pc), 32'h4);
      check_vec("dbg_step_dbg", 32'(qdbg), 32'h1);
      ce = 1'b1;
      tick();
      ce = 1'b0;
      pulses = 0;
      for (int k = 0; k < 18; k++) begin
         tick();
         if (qce) pulses++;
      end
      check_vec("dbg_held_step_issues", pulses, 0);
      step = 1'b0;
      tick();
      step = 1'b1;
      tick();
      check_vec("dbg_step2_ce", 32'(qce), 32'h1);
      check_vec("dbg_step2_pc", 32'(pc), 32'h5);
      step = 1'b0;
      mode = 1'b0;
      tick();

      // Branch with same-cycle i_ce, 3 idle cycles, then target
      br = 1'b1; tgt = 16'h0040; ce = 1'b1;
      tick();
      br = 1'b0; ce = 1'b0;
      check_vec("flush_idle0", 32'(qce), 32'h0);
      tick();
      check_vec("flush_idle1", 32'(qce), 32'h0);
      tick();
      check_vec("flush_idle2", 32'(qce), 32'h0);
      tick();
      check_vec("br_ce", 32'(qce), 32'h1);
      check_vec("br_pc", 32'(pc), 32'h40);
      tick();
      tick();
      check_vec("br_ce_ignored", 32'(qce), 32'h0);
      check_vec("br_ce_ignored_pc", 32'(pc), 32'h40);

      // Retarget inside the flush window
      br = 1'b1; tgt = 16'h0060;
      tick();
      tgt = 16'h0080;
      tick();
      br = 1'b0;
      check_vec("retarget_idle0", 32'(qce), 32'h0);
      tick();
      check_vec("retarget_idle1", 32'(qce), 32'h0);
      tick();
      check_vec("retarget_idle2", 32'(qce), 32'h0);
      tick();
      check_vec("retarget_ce", 32'(qce), 32'h1);
      check_vec("retarget_pc", 32'(pc), 32'h80);
      tick();

      // Asynchronous reset mid-flush
      br = 1'b1; tgt = 16'h0100;
      tick();
      br = 1'b0;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check_vec("async_rst_ce", 32'(qce), 32'h0);
      check_vec("async_rst_pc", 32'(pc), 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check_vec("refetch_ce", 32'(qce), 32'h1);
      check_vec("refetch_pc", 32'(pc), 32'h0);
      check_vec("w4_init_ce", 32'(qce4), 32'h1);
      check_vec("w4_init_pc", 32'(pc4), 32'h0);

      // 4-bit instance: zero-length flush, wrap, halt over branch
      tick();
      check_vec("refetch_quiet", 32'(qce), 32'h0);
      br4 = 1'b1; tgt4 = 4'hE;
      tick();
      br4 = 1'b0;
      check_vec("w4_direct_br_ce", 32'(qce4), 32'h1);
      check_vec("w4_direct_br_pc", 32'(pc4), 32'hE);
      ce4 = 1'b1;
      tick();
      ce4 = 1'b0;
      tick();
      check_vec("w4_pc_f", 32'(pc4), 32'hF);
      ce4 = 1'b1;
      tick();
      ce4 = 1'b0;
      tick();
      check_vec("w4_wrap_ce", 32'(qce4), 32'h1);
      check_vec("w4_wrap_pc", 32'(pc4), 32'h0);
      check_vec("no_stale_target", 32'(pc), 32'h0);
      halt4 = 1'b1; br4 = 1'b1; tgt4 = 4'h3;
      tick();
      halt4 = 1'b0; br4 = 1'b0;
      check_vec("w4_halted", 32'(qhalt4), 32'h1);
      check_vec("w4_halt_ce", 32'(qce4), 32'h0);
      ce4 = 1'b1;
      tick();
      ce4 = 1'b0;
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (qce4) pulses++;
      end
      check_vec("w4_halt_no_issue", pulses, 0);
      check_vec("w4_halt_sticky", 32'(qhalt4), 32'h1);
      check_vec("w4_halt_pc", 32'(pc4), 32'h0);

`ifdef PRCO_BREAKPOINT_EN
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      bp_we = 1'b1; bp_idx = 1'b0; bp_addr = 16'h0005;
      tick();
      bp_we = 1'b0;
      check_vec("bp_init_pc", 32'(pc), 32'h0);
      for (int k = 1; k <= 4; k++) begin
         ce = 1'b1;
         tick();
         ce = 1'b0;
         tick();
         check_vec("bp_run_pc", 32'(pc), 32'(k));
      end
      ce = 1'b1;
      tick();
      ce = 1'b0;
      tick();
      check_vec("bp_stop_ce", 32'(qce), 32'h0);
      check_vec("bp_hit", 32'(qbp), 32'h1);
      check_vec("bp_stop_pc", 32'(pc), 32'h4);
      tick();
      check_vec("bp_hold_ce", 32'(qce), 32'h0);
      step = 1'b1;
      tick();
      step = 1'b0;
      check_vec("bp_step_ce", 32'(qce), 32'h1);
      check_vec("bp_step_pc", 32'(pc), 32'h5);
      check_vec("bp_step_clear", 32'(qbp), 32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
